or1200_keccak_wbstage: RTL

Result staging stage between the Keccak coprocessor core and `or1200_wbmux`. It buffers 64-bit lanes produced by the core in a small FIFO and hands them to the pipeline as 32-bit words on `keccak_dataout`, which drives the wbmux `muxin_keccak` input. It also raises a stall when a Keccak read instruction arrives and no data is buffered. It honours `wb_freeze` so that the writeback value stays coherent with the rest of the pipeline.

---
 rtl/or1200_keccak_wbstage.sv | 101 ++++++++++
 1 files changed

// File: rtl/or1200_keccak_wbstage.sv
// or1200_keccak_wbstage
//   Result staging between the Keccak coprocessor core and or1200_wbmux.
//   64-bit lanes from the core are buffered in a DEPTH-entry FIFO and
//   delivered to the pipeline one 32-bit word per accepted read.
//
// Ports
//   clk, rst          pipeline clock, asynchronous active-high reset
//   lane_valid/_data  lane offered by the core
//   lane_ready        FIFO not full (current occupancy only)
//   rd_req            Keccak read instruction wants its next word
//   wb_freeze         writeback freeze, blocks read acceptance
//   flush             synchronous clear of buffered data
//   keccak_dataout    registered word to wbmux muxin_keccak
//   keccak_dout_valid pulse: keccak_dataout updated on the previous edge
//   keccak_stall      read requested while nothing is buffered
//   level             occupied lane entries
module or1200_keccak_wbstage #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int HI_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lane_valid,
  input  logic [63:0]   lane_data,
  output logic          lane_ready,
  input  logic          rd_req,
  input  logic          wb_freeze,
  input  logic          flush,
  output logic [31:0]   keccak_dataout,
  output logic          keccak_dout_valid,
  output logic          keccak_stall,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic        HF   = (HI_FIRST != 0);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          hsel;

  logic          push;
  logic          accept;
  logic          free;
  logic          take_hi;
  logic [31:0]   rd_word;

  always_comb begin
    lane_ready   = (count != FULL);
    push         = lane_valid && lane_ready;
    accept       = rd_req && !wb_freeze && (count != '0);
    keccak_stall = rd_req && !wb_freeze && (count == '0);
    // Second half of a lane frees the entry.
    free         = accept && hsel;
    take_hi      = hsel ^ HF;
    rd_word      = take_hi ? mem[rd_ptr][63:32] : mem[rd_ptr][31:0];
    level        = count;
  end

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= lane_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      hsel              <= 1'b0;
      keccak_dataout    <= '0;
      keccak_dout_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      hsel              <= 1'b0;
      keccak_dout_valid <= 1'b0;
    end else begin
      keccak_dout_valid <= accept;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (accept) begin
        keccak_dataout <= rd_word;
        hsel           <= ~hsel;
      end
      if (free)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, free})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
